// File: rtl/addsub_pkg.sv
// Shared definitions for the add/subtract arbiter: operation modes,
// response-register state encoding and the round-robin pointer helper.
package addsub_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Pointer to the index after p, wrapping at n (pointer width covers n <= 8)
    function automatic logic [2:0] next_ptr(input logic [2:0] p, input int n);
        if (int'(p) + 1 >= n) begin
            return 3'd0;
        end
        return p + 3'd1;
    endfunction

endpackage

// File: rtl/addSub.sv
// Combinational N-bit adder/subtractor with carry-in and carry/borrow flag.
module addSub #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic [N-1:0] sum,
    output logic         flag
);

    logic [N:0] add_w;
    logic [N:0] sub_w;

    // Extended-width add and subtract; the top bit is carry or borrow
    always_comb begin
        add_w = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
        sub_w = {1'b0, a} - {1'b0, b};
        if (sub) begin
            {flag, sum} = sub_w;
        end else begin
            {flag, sum} = add_w;
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requesting index at or after ptr wins;
// ptr moves past the winner whenever the grant is consumed.
module rr_arbiter
    import addsub_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic                    advance,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] gidx,
    output logic                    any
);

    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;

    // Scan requests starting at ptr and pick the first one set
    always_comb begin
        grant = '0;
        gidx  = '0;
        any   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(ptr_q) + k) % NREQ;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                gidx       = IDW'(idx);
            end
        end
    end

    // Advance the pointer one past the winner when its request is taken
    always_comb begin
        ptr_d = ptr_q;
        if (advance && any) begin
            ptr_d = IDW'(next_ptr(3'(gidx), NREQ));
        end
    end

    // Pointer register
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/addsub_arbiter.sv
// Shares one addSub unit among NREQ valid/ready requesters; results come
// back through a single registered response channel tagged with the winner.
module addsub_arbiter
    import addsub_pkg::*;
#(
    parameter int N    = 8,
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    input  logic [NREQ-1:0]   req_mode,
    input  logic [NREQ-1:0]   req_cin,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [N-1:0]      rsp_sum,
    output logic              rsp_flag,
    output logic [15:0]       ops_count
);

    state_t         state_q, state_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [N-1:0]   rsp_sum_q, rsp_sum_d;
    logic           rsp_flag_q, rsp_flag_d;
    logic [15:0]    ops_q, ops_d;

    logic            acc;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gidx;
    logic            any;
    logic [N-1:0]    op_a, op_b;
    logic            op_mode, op_cin;
    logic [N-1:0]    au_sum;
    logic            au_flag;

    // The register can take a new result when empty or being drained;
    // nothing is accepted while reset is asserted
    always_comb begin
        acc       = (state_q == ST_EMPTY || rsp_ready) && !rst;
        req_ready = acc ? grant : '0;
    end

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (acc),
        .grant   (grant),
        .gidx    (gidx),
        .any     (any)
    );

    // Route the winner's operands to the shared unit; carry-in only in add mode
    always_comb begin
        op_a    = req_a[int'(gidx)*N +: N];
        op_b    = req_b[int'(gidx)*N +: N];
        op_mode = req_mode[gidx];
        op_cin  = (op_mode == MODE_SUB) ? 1'b0 : req_cin[gidx];
    end

    addSub #(.N(N)) u_addsub (
        .a    (op_a),
        .b    (op_b),
        .cin  (op_cin),
        .sub  (op_mode),
        .sum  (au_sum),
        .flag (au_flag)
    );

    // Response FSM: load on grant, drain when consumed with nothing to load
    always_comb begin
        state_d    = state_q;
        rsp_id_d   = rsp_id_q;
        rsp_sum_d  = rsp_sum_q;
        rsp_flag_d = rsp_flag_q;
        ops_d      = ops_q;
        if (acc) begin
            if (any) begin
                state_d    = ST_FULL;
                rsp_id_d   = gidx;
                rsp_sum_d  = au_sum;
                rsp_flag_d = au_flag;
                ops_d      = ops_q + 16'd1;
            end else if (state_q == ST_FULL) begin
                state_d = ST_EMPTY;
            end
        end
    end

    // Response register and accept counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            rsp_id_q   <= '0;
            rsp_sum_q  <= '0;
            rsp_flag_q <= 1'b0;
            ops_q      <= '0;
        end else begin
            state_q    <= state_d;
            rsp_id_q   <= rsp_id_d;
            rsp_sum_q  <= rsp_sum_d;
            rsp_flag_q <= rsp_flag_d;
            ops_q      <= ops_d;
        end
    end

    assign rsp_valid = (state_q == ST_FULL);
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_flag  = rsp_flag_q;
    assign ops_count = ops_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: directed steps plus random traffic against a
// behavioural model of the round-robin scheduler and response register.
module tb_addsub_arbiter;

    localparam int N    = 8;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ-1:0]   req_mode;
    logic [NREQ-1:0]   req_cin;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [N-1:0]      rsp_sum;
    logic              rsp_flag;
    logic [15:0]       ops_count;

    addsub_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_mode  (req_mode),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_flag  (rsp_flag),
        .ops_count (ops_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Requester stimulus
    int va[NREQ];
    int ta[NREQ];
    int tb[NREQ];
    int tm[NREQ];
    int tc[NREQ];

    // Reference model state
    int m_valid, m_id, m_sum, m_flag, m_ptr, m_ops;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // First valid requester at or after the model pointer, or -1
    function automatic int pick();
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (va[i] != 0) return i;
        end
        return -1;
    endfunction

    // One clock: drive inputs, check the combinational grant, then the registered result
    task automatic step(input int rstv, input int rrdy);
        int g, acc, s;
        logic [NREQ-1:0] exp_ready;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]      = (va[i] != 0);
            req_a[i*N +: N]   = ta[i][N-1:0];
            req_b[i*N +: N]   = tb[i][N-1:0];
            req_mode[i]       = (tm[i] != 0);
            req_cin[i]        = (tc[i] != 0);
        end
        rst       = (rstv != 0);
        rsp_ready = (rrdy != 0);
        #1;
        g   = pick();
        acc = (m_valid == 0 || rrdy != 0) && rstv == 0;
        exp_ready = '0;
        if (acc && g >= 0) exp_ready[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        @(posedge clk);
        if (rstv != 0) begin
            m_valid = 0; m_id = 0; m_sum = 0; m_flag = 0; m_ptr = 0; m_ops = 0;
        end else if (acc) begin
            if (g >= 0) begin
                if (tm[g] == 0) begin
                    s      = ta[g] + tb[g] + tc[g];
                    m_sum  = s % 256;
                    m_flag = (s >= 256);
                end else begin
                    m_sum  = (ta[g] - tb[g] + 256) % 256;
                    m_flag = (ta[g] < tb[g]);
                end
                m_id    = g;
                m_valid = 1;
                m_ptr   = (g + 1) % NREQ;
                m_ops   = (m_ops + 1) % 65536;
            end else if (rrdy != 0) begin
                m_valid = 0;
            end
        end
        #1;
        chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        chk("rsp_id",    32'(rsp_id),    32'(m_id));
        chk("rsp_sum",   32'(rsp_sum),   32'(m_sum));
        chk("rsp_flag",  32'(rsp_flag),  32'(m_flag));
        chk("ops_count", 32'(ops_count), 32'(m_ops));
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NREQ; i++) begin
            va[i] = 0; ta[i] = 0; tb[i] = 0; tm[i] = 0; tc[i] = 0;
        end
    endtask

    task automatic set_req(input int i, input int a, input int b, input int m, input int c);
        va[i] = 1; ta[i] = a; tb[i] = b; tm[i] = m; tc[i] = c;
    endtask

    initial begin
        int exp_ids[6];
        logic [N-1:0] held_sum;
        logic [IDW-1:0] held_id;
        clear_reqs();
        m_valid = 0; m_id = 0; m_sum = 0; m_flag = 0; m_ptr = 0; m_ops = 0;
        @(negedge clk);

        // Reset state
        step(1, 0);
        step(1, 1);
        chk("reset_valid", 32'(rsp_valid), 32'd0);
        chk("reset_ops", 32'(ops_count), 32'd0);

        // Single add on requester 0
        @(negedge clk);
        set_req(0, 18, 20, 0, 0);
        step(0, 1);
        chk("add_id", 32'(rsp_id), 32'd0);
        chk("add_sum", 32'(rsp_sum), 32'd38);
        chk("add_flag", 32'(rsp_flag), 32'd0);
        chk("add_ops", 32'(ops_count), 32'd1);
        clear_reqs();

        // Subtract, add overflow, subtract with borrow and ignored carry-in
        @(negedge clk);
        set_req(1, 200, 46, 1, 0);
        step(0, 1);
        chk("sub_sum", 32'(rsp_sum), 32'd154);
        chk("sub_flag", 32'(rsp_flag), 32'd0);
        clear_reqs();
        @(negedge clk);
        set_req(2, 228, 50, 0, 0);
        step(0, 1);
        chk("ovf_sum", 32'(rsp_sum), 32'd22);
        chk("ovf_flag", 32'(rsp_flag), 32'd1);
        clear_reqs();
        @(negedge clk);
        set_req(3, 33, 50, 1, 1);
        step(0, 1);
        chk("borrow_id", 32'(rsp_id), 32'd3);
        chk("borrow_sum", 32'(rsp_sum), 32'd239);
        chk("borrow_flag", 32'(rsp_flag), 32'd1);
        clear_reqs();

        // Round-robin with all requesters valid
        exp_ids = '{0, 1, 2, 3, 0, 1};
        for (int i = 0; i < NREQ; i++) set_req(i, 10 * i + 1, i, i % 2, 1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            step(0, 1);
            chk("rr_id", 32'(rsp_id), 32'(exp_ids[k]));
            chk("rr_onehot", 32'($onehot(req_ready) || req_ready == '0), 32'd1);
        end
        clear_reqs();

        // Back-pressure with requesters 1 and 2 pending
        set_req(1, 5, 7, 0, 1);
        set_req(2, 9, 3, 1, 0);
        @(negedge clk);
        step(0, 1);
        held_sum = rsp_sum;
        held_id  = rsp_id;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            step(0, 0);
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_sum_hold", 32'(rsp_sum), 32'(held_sum));
            chk("bp_id_hold", 32'(rsp_id), 32'(held_id));
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            step(0, 1);
        end

        // Reset while full with two requests pending
        @(negedge clk);
        step(0, 0);
        @(negedge clk);
        step(1, 0);
        chk("rst_mid_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mid_ops", 32'(ops_count), 32'd0);
        @(negedge clk);
        step(0, 1);
        chk("rst_first_grant", 32'(rsp_id), 32'd1);
        clear_reqs();

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                va[i] = ($urandom_range(0, 2) != 0);
                ta[i] = $urandom_range(0, 255);
                tb[i] = $urandom_range(0, 255);
                tm[i] = $urandom_range(0, 1);
                tc[i] = $urandom_range(0, 1);
            end
            @(negedge clk);
            step(($urandom_range(0, 63) == 0) ? 1 : 0, $urandom_range(0, 3) != 0);
        end
        clear_reqs();

        // Counter wrap: 65536 accepts of 255+1+1
        @(negedge clk);
        step(1, 1);
        set_req(0, 255, 1, 0, 1);
        for (int k = 0; k < 65536; k++) begin
            @(negedge clk);
            step(0, 1);
        end
        chk("wrap_sum", 32'(rsp_sum), 32'd1);
        chk("wrap_flag", 32'(rsp_flag), 32'd1);
        chk("wrap_ops", 32'(ops_count), 32'd0);
        clear_reqs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Round-robin scheduler that shares one `addSub #(N)` add/subtract unit among `NREQ` requesters. Each requester uses a valid/ready request channel. Results return on a single registered response channel tagged with the requester index. Throughput is one operation per cycle when the response channel is not back-pressured. The block sits between client datapaths and the shared arithmetic unit, which is instantiated inside it.

## Interface
- `N`, 8: operand/result width.
- `NREQ`, 4: number of requesters, 2..8.
- `IDW`, `$clog2(NREQ)`: width of the response tag.

- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input NREQ: request present, one bit per requester.
- `req_ready` output NREQ: request accepted this cycle; one-hot or zero.
- `req_a` input NREQ*N: operand A, requester i at `[i*N +: N]`.
- `req_b` input NREQ*N: operand B, same packing.
- `req_mode` input NREQ: 0 = add, 1 = subtract.
- `req_cin` input NREQ: carry-in, used in add mode only.
- `rsp_valid` output 1: response register holds a result.
- `rsp_ready` input 1: consumer takes the response.
- `rsp_id` output IDW: index of the requester that produced the result.
- `rsp_sum` output N: result.
- `rsp_flag` output 1: carry-out in add mode, borrow in subtract mode.
- `ops_count` output 16: number of completed accepts, wraps.

## Operation
- **Accept condition:** `acc = !rsp_valid || rsp_ready`.
- **Grant:** round-robin over the `req_valid` bits, starting at pointer `ptr`. The first valid index at or after `ptr`, modulo NREQ, wins. `req_ready[g] = acc && req_valid[g]`; all other bits are 0.
- **Arithmetic:** the winner's fields are muxed onto the `addSub` inputs.
  - Add (mode 0): `sum = (A+B+cin) mod 2^N`, `flag = carry out of bit N-1`.
  - Subtract (mode 1): `cin` is forced to 0 at the unit. `sum = (A-B) mod 2^N`, `flag = (A < B)` unsigned.
- **On accept with a grant:**
  - Register `sum`, `flag` and `g` into the rsp fields.
  - Set `rsp_valid=1`.
  - Set `ptr = (g+1) mod NREQ`.
  - Increment `ops_count`.
- **On `acc` with no valid request:** clear `rsp_valid` if `rsp_ready`; `ptr` is unchanged.
- **Stall:** while `rsp_valid && !rsp_ready`, all `req_ready=0` and the rsp fields hold stable.
- **FSM:**
  - States are EMPTY (`rsp_valid=0`) and FULL (`rsp_valid=1`).
  - EMPTY→FULL on a grant.
  - FULL→FULL on `rsp_ready` plus a grant, or on `!rsp_ready`.
  - FULL→EMPTY on `rsp_ready` with no grant.
- **Request stability:** a requester must hold `req_valid` and its operands until it sees `req_ready`. Dropping `req_valid` earlier is permitted, and that requester is then skipped.
- **Ignored inputs:** `req_cin` is ignored when `req_mode=1`. Operands on non-granted lanes are don't-care.

## Timing
- **Reset values:** `rsp_valid=0`, `rsp_id=0`, `rsp_sum=0`, `rsp_flag=0`, `ptr=0`, `ops_count=0`, `req_ready=0`.
- **`req_ready` is combinational** from `req_valid`, `rsp_valid`, `rsp_ready` and `ptr`. It has no combinational path from the operands.
- **Latency:** 1 cycle. A request accepted at edge k appears on rsp outputs after edge k, and `rsp_valid` is high in cycle k+1.
- **Back-to-back:** with `rsp_ready` held at 1, one result per cycle. A response consumed and a new request accepted on the same edge is legal; the register is overwritten.
- **Fairness:** with all NREQ requesters continuously valid, grants rotate 0,1,…,NREQ-1,0. Any continuously valid requester is served within NREQ accepts.
- **Reset mid-operation:** when `rst` is sampled high, any pending response is discarded. `req_ready` is 0 during the reset cycle; the outputs reach the reset values listed above on the next edge.
- **Wrap-around:**
  - `ops_count` wraps from 65535 to 0.
  - `ptr` wraps from NREQ-1 to 0.
  - Arithmetic results wrap modulo 2^N, with the carry or borrow reported in `rsp_flag`.

## Structure
- Shared package `addsub_pkg`:
  - Localparams `MODE_ADD=1'b0` and `MODE_SUB=1'b1`.
  - The state encoding `ST_EMPTY`/`ST_FULL`.
  - A function computing `(ptr+1) mod NREQ`.
- Sub-module `rr_arbiter #(NREQ)`:
  - Inputs: `clk`, `rst`, `req`, `advance`.
  - Outputs: one-hot `grant`, index `gidx`, `any`.
  - Owns `ptr`.
- Top level:
  - Instantiates `rr_arbiter` and `addSub #(N)`.
  - Contains the operand muxes, the response register and `ops_count`.
- Target RTL size: 150–250 lines.

## Test plan
- **Single add:** req0 sends A=18, B=20, mode 0, cin 0 → one cycle later `rsp_id=0`, `sum=38`, `flag=0`; `ops_count=1`.
- **Subtract and add overflow:**
  - req1 sends 200−46 → `sum=154`, `flag=0`.
  - req2 sends 228+50 → `sum=22`, `flag=1`.
  - req3 sends 33−50 → `sum=239`, `flag=1`.
  - Confirm `cin=1` is ignored in subtract.
- **Round-robin:** all four valid, `rsp_ready=1` → ids appear 0,1,2,3,0,1 on consecutive cycles; `req_ready` is one-hot every cycle.
- **Back-pressure:** `rsp_ready=0` for 3 cycles with req1 and req2 valid → `rsp_valid` held, rsp fields stable, `req_ready=0`. Release → grants resume in round-robin order.
- **Reset mid-stream:** assert `rst` for 1 cycle while FULL with 2 requests pending → next cycle `rsp_valid=0`, `ops_count=0`; the first grant after reset goes to the lowest valid index.
- **Counter wrap:** preload via 65536 accepts of req0 with A=255, B=1, cin=1 → each result is `sum=1`, `flag=1`; `ops_count` returns to 0.
